// File: rtl/decoder_sched_pkg.sv
// Shared definitions for the decoder layer scheduler: FSM state encoding and default widths.
// Optional watchdog is enabled with DECODER_SCHED_WATCHDOG_EN.
package decoder_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  localparam int unsigned IMEM_ADDR_W_DEF = 10;
  localparam int unsigned LAYER_W_DEF     = 8;
  localparam int unsigned GAP_W_DEF       = 8;
  localparam int unsigned WDOG_W_DEF      = 20;

endpackage

// File: rtl/decoder_sched_wdog.sv
// RUN-phase watchdog counter for decoder_sched; only built with DECODER_SCHED_WATCHDOG_EN.
// expire_o fires on the RUN cycle whose increment brings the counter to all-ones.
`ifdef DECODER_SCHED_WATCHDOG_EN
module decoder_sched_wdog #(
  parameter int unsigned WDOG_W = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [WDOG_W-1:0] LAST_BEFORE_FULL = ~WDOG_W'(1);

  logic [WDOG_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + WDOG_W'(1);
    end
  end

  assign expire_o = run_i && (cnt_q == LAST_BEFORE_FULL);

endmodule
`endif

// File: rtl/decoder_sched.sv
// Multi-layer decoder scheduler: sequences decoder layers, relocates fetch addresses per layer.
// Define DECODER_SCHED_WATCHDOG_EN to add the RUN-phase watchdog and sticky err_timeout.
module decoder_sched
  import decoder_sched_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W = IMEM_ADDR_W_DEF,
  parameter int unsigned LAYER_W     = LAYER_W_DEF,
  parameter int unsigned GAP_W       = GAP_W_DEF,
  parameter int unsigned WDOG_W      = WDOG_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic [LAYER_W-1:0]     cfg_num_layers,
  input  logic [GAP_W-1:0]       cfg_gap,
  input  logic [IMEM_ADDR_W-1:0] cfg_base_addr,
  output logic                   dec_start,
  input  logic                   dec_done,
  input  logic                   dec_imem_read_req,
  input  logic [IMEM_ADDR_W-1:0] dec_imem_read_addr,
  output logic                   imem_read_req,
  output logic [IMEM_ADDR_W-1:0] imem_read_addr,
  output logic                   busy,
  output logic                   sched_done,
  output logic [LAYER_W-1:0]     layer_idx,
  output logic                   err_timeout
);

  sched_state_e           state_q, state_d;
  logic [IMEM_ADDR_W-1:0] base_q, base_d;
  logic [IMEM_ADDR_W-1:0] hw_q, hw_d, hw_run;
  logic [LAYER_W-1:0]     count_q, count_d;
  logic [LAYER_W-1:0]     layer_q, layer_d, layer_inc;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d, gap_cnt_inc;
  logic                   timeout;

`ifdef DECODER_SCHED_WATCHDOG_EN
  logic err_q;

  decoder_sched_wdog #(
    .WDOG_W(WDOG_W)
  ) u_wdog (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (state_q == ST_START),
    .run_i   (state_q == ST_RUN),
    .expire_o(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == ST_IDLE && cfg_start) begin
      err_q <= 1'b0;
    end else if (state_q == ST_RUN && !dec_done && timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout = 1'b0;
  // WDOG_W only sizes the watchdog, which this build does not contain.
  assign err_timeout = 1'b0 & (WDOG_W != 0);
`endif

  assign layer_inc   = layer_q + LAYER_W'(1);
  assign gap_cnt_inc = gap_cnt_q + GAP_W'(1);
  // An address fetched in the dec_done cycle still counts toward the next base.
  assign hw_run = (dec_imem_read_req && (dec_imem_read_addr > hw_q)) ? dec_imem_read_addr : hw_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    hw_d      = hw_q;
    count_d   = count_q;
    layer_d   = layer_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          count_d = cfg_num_layers;
          gap_d   = cfg_gap;
          base_d  = cfg_base_addr;
          layer_d = '0;
          state_d = (cfg_num_layers == '0) ? ST_DONE : ST_START;
        end
      end
      ST_START: begin
        hw_d      = '0;
        gap_cnt_d = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        hw_d = hw_run;
        if (dec_done) begin
          base_d  = base_q + hw_run + IMEM_ADDR_W'(1);
          layer_d = layer_inc;
          if (layer_inc == count_q) begin
            state_d = ST_DONE;
          end else if (gap_q == '0) begin
            state_d = ST_START;
          end else begin
            state_d = ST_GAP;
          end
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_inc == gap_q) begin
          gap_cnt_d = '0;
          state_d   = ST_START;
        end else begin
          gap_cnt_d = gap_cnt_inc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      hw_q      <= '0;
      count_q   <= '0;
      layer_q   <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      hw_q      <= hw_d;
      count_q   <= count_d;
      layer_q   <= layer_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign dec_start      = (state_q == ST_START);
  assign sched_done     = (state_q == ST_DONE);
  assign busy           = (state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_GAP);
  assign layer_idx      = layer_q;
  assign imem_read_req  = dec_imem_read_req;
  assign imem_read_addr = base_q + dec_imem_read_addr;

endmodule
